// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Turns one raw, bouncing, active-low push-button into a clean debounced
//   level plus single-cycle press, release and auto-repeat events.
//
// Ports:
//   i_clk           system clock
//   i_rst           synchronous, active-high reset
//   i_key_n         raw key input, asynchronous, 0 = pressed
//   o_pressed       debounced level, 1 = pressed
//   o_press_pulse   one-cycle pulse when a press is accepted
//   o_release_pulse one-cycle pulse when a release is accepted
//   o_repeat_pulse  one-cycle pulse per auto-repeat while the key is held
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_repeat_pulse
);

  localparam int CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_TOP = (HOLD_MAX > 2) ? HOLD_MAX : 2;
  localparam int HOLD_W   = $clog2(HOLD_TOP);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic              HOLD_EN   = (HOLD_CYCLES != 0);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_s;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_repeating;
  logic              r_pressed;
  logic              r_press_pulse;
  logic              r_release_pulse;
  logic              r_repeat_pulse;

  // Two-flop synchronizer; resets to "released" so a held key is re-qualified.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  // Debounce FSM with hold / auto-repeat timing and registered event pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_RELEASED;
      r_cnt           <= CNT_ZERO;
      r_hold_cnt      <= HOLD_ZERO;
      r_repeating     <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_repeat_pulse  <= 1'b0;
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_repeat_pulse  <= 1'b0;
      case (r_state)
        S_RELEASED: begin
          if (!w_s) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= S_RELEASED;
          end
        end
        S_PRESS_WAIT: begin
          if (w_s) begin
            r_state <= S_RELEASED;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= S_PRESSED;
            r_cnt         <= CNT_ZERO;
            r_pressed     <= 1'b1;
            r_press_pulse <= 1'b1;
            r_hold_cnt    <= HOLD_ZERO;
            r_repeating   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (w_s) begin
            r_state <= S_RELEASE_WAIT;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= S_PRESSED;
          end
          // Hold timing advances on every cycle spent in S_PRESSED, including
          // the one that leaves for S_RELEASE_WAIT, so a release bounce delays
          // the next repeat by exactly the cycles spent waiting.
          if (HOLD_EN) begin
            if (!r_repeating && (r_hold_cnt == HOLD_LAST)) begin
              r_repeat_pulse <= 1'b1;
              r_repeating    <= 1'b1;
              r_hold_cnt     <= HOLD_ZERO;
            end else if (r_repeating && (r_hold_cnt == REP_LAST)) begin
              r_repeat_pulse <= 1'b1;
              r_hold_cnt     <= HOLD_ZERO;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end
          end else begin
            r_hold_cnt <= HOLD_ZERO;
          end
        end
        S_RELEASE_WAIT: begin
          // hold counter is deliberately left untouched here (frozen)
          if (!w_s) begin
            r_state <= S_PRESSED;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state         <= S_RELEASED;
            r_cnt           <= CNT_ZERO;
            r_pressed       <= 1'b0;
            r_release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state   <= S_RELEASED;
          r_cnt     <= CNT_ZERO;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign o_pressed       = r_pressed;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_repeat_pulse  = r_repeat_pulse;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Self-checking bench for key_debounce (DEBOUNCE=4, HOLD=20, REPEAT=8).
//   A behavioural model built on sample run-lengths and elapsed-hold timers
//   predicts every output each cycle; directed scenarios additionally check
//   absolute event edges.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_key_n = 1'b1;
  logic o_pressed, o_press_pulse, o_release_pulse, o_repeat_pulse;

  key_debounce #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_key_n(i_key_n),
    .o_pressed(o_pressed), .o_press_pulse(o_press_pulse),
    .o_release_pulse(o_release_pulse), .o_repeat_pulse(o_repeat_pulse)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // reference model state
  logic m_sync1 = 1'b1, m_sync2 = 1'b1;
  int   m_level = 0;      // debounced pressed level
  int   m_run   = 0;      // consecutive samples disagreeing with m_level
  int   m_elapsed = 0;    // hold cycles counted toward the next repeat
  int   m_target  = H;    // cycles needed for the next repeat
  int   e_press, e_release, e_repeat;

  // event log
  int last_press = -1, last_release = -1;
  int n_press = 0, n_release = 0;
  int rep_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic key, input logic rst);
    int pressed_sample, old_level, was_stable;
    e_press = 0; e_release = 0; e_repeat = 0;
    if (rst) begin
      m_sync1 = 1'b1; m_sync2 = 1'b1;
      m_level = 0; m_run = 0; m_elapsed = 0; m_target = H;
    end else begin
      pressed_sample = (m_sync2 == 1'b0) ? 1 : 0;
      old_level  = m_level;
      was_stable = (m_run == 0);
      if (pressed_sample != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = pressed_sample;
          m_run = 0;
          if (m_level == 1) begin
            e_press = 1; m_elapsed = 0; m_target = H;
          end else begin
            e_release = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      // time accrues only while settled in the pressed state
      if (H != 0 && old_level == 1 && was_stable) begin
        m_elapsed++;
        if (m_elapsed == m_target) begin
          e_repeat = 1; m_elapsed = 0; m_target = R;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = key;
    end
  endtask

  task automatic step(input logic key, input logic rst);
    i_key_n = key;
    i_rst   = rst;
    @(posedge i_clk);
    cyc++;
    model_edge(key, rst);
    #1;
    check("pressed", int'(o_pressed), m_level);
    check("press_pulse", int'(o_press_pulse), e_press);
    check("release_pulse", int'(o_release_pulse), e_release);
    check("repeat_pulse", int'(o_repeat_pulse), e_repeat);
    if (o_press_pulse)   begin last_press = cyc; n_press++; end
    if (o_release_pulse) begin last_release = cyc; n_release++; end
    if (o_repeat_pulse)  rep_q.push_back(cyc);
  endtask

  function automatic int rep_at(input int idx);
    return (rep_q.size() > idx) ? rep_q[idx] : -1;
  endfunction

  int k, p, r, np, nr, len, key_lvl;

  initial begin
    // reset held with key pressed: every output low
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("rst_pressed", int'(o_pressed), 0);

    // clean press first sampled at edge 10
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    rep_q.delete();
    k = cyc + 1;
    for (int i = 0; i < 45; i++) step(1'b0, 1'b0);
    check("press_edge", last_press, 15);
    check("press_edge_rel", last_press, k + D + 1);
    p = last_press;
    check("rep_count", rep_q.size(), 3);
    check("rep0", rep_at(0), p + 20);
    check("rep1", rep_at(1), p + 28);
    check("rep2", rep_at(2), p + 36);

    // release, then no further repeats
    r = cyc + 1;
    rep_q.delete();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("release_edge", last_release, r + D + 1);
    check("rep_after_release", rep_q.size(), 0);

    // glitches: five low-3 / high-1 bursts are ignored
    np = n_press;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("glitch_no_press", n_press, np);
    check("glitch_level", int'(o_pressed), 0);
    k = cyc + 1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("after_glitch_press", last_press, k + D + 1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

    // release bounce while held delays the next repeat by 2 cycles
    rep_q.delete();
    nr = n_release;
    k = cyc + 1;
    while (cyc < k + D + 1 + 21) step(1'b0, 1'b0);
    p = k + D + 1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    while (cyc < p + 40) step(1'b0, 1'b0);
    check("bounce_level", int'(o_pressed), 1);
    check("bounce_no_release", n_release, nr);
    check("bounce_rep0", rep_at(0), p + 20);
    check("bounce_rep1", rep_at(1), p + 30);
    check("bounce_rep2", rep_at(2), p + 38);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

    // reset mid-press with the key still held
    nr = n_release;
    k = cyc + 1;
    while (cyc < k + D + 1 + 9) step(1'b0, 1'b0);
    p = k + D + 1;
    step(1'b0, 1'b1);
    check("midrst_pressed", int'(o_pressed), 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("midrst_no_release", n_release, nr);
    check("midrst_repress", last_press, p + 16);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

    // randomized key activity with occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      key_lvl = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) len = $urandom_range(25, 60);
      else                           len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++)
        step(logic'(key_lvl), ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
